// File: rtl/sd_init_pkg.sv
// Shared constants for the SD card initialisation sequencer.
// Contains command indices, the CMD8 echo pattern, state and error encodings, and the command builder.
package sd_init_pkg;

  localparam logic [5:0] CMD0    = 6'd0;
  localparam logic [5:0] CMD2    = 6'd2;
  localparam logic [5:0] CMD3    = 6'd3;
  localparam logic [5:0] CMD8    = 6'd8;
  localparam logic [5:0] CMD55   = 6'd55;
  localparam logic [5:0] ACMD41  = 6'd41;
  // Marker for "no command left": selecting it at the end of GAP leads to DONE.
  localparam logic [5:0] SEL_END = 6'd63;

  localparam logic [11:0] CMD8_CHECK = 12'h1AA;
  localparam logic [31:0] CMD8_ARG   = 32'h0000_01AA;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD8    = 3'd1;
  localparam logic [2:0] ERR_RESP_TO = 3'd2;
  localparam logic [2:0] ERR_RETRY   = 3'd3;
  localparam logic [2:0] ERR_TX_TO   = 3'd4;

  typedef enum logic [3:0] {
    ST_IDLE          = 4'd0,
    ST_ISSUE         = 4'd1,
    ST_WAIT_TX_START = 4'd2,
    ST_WAIT_TX_END   = 4'd3,
    ST_WAIT_RESP     = 4'd4,
    ST_EVAL          = 4'd5,
    ST_GAP           = 4'd6,
    ST_DONE          = 4'd7,
    ST_ERROR         = 4'd8
  } state_t;

  function automatic logic [37:0] build_cmd(input logic [5:0]  sel,
                                            input logic [15:0] rca,
                                            input logic [31:0] acmd41_arg);
    logic [31:0] arg;
    case (sel)
      CMD8:    arg = CMD8_ARG;
      CMD55:   arg = {rca, 16'h0000};
      ACMD41:  arg = acmd41_arg;
      default: arg = 32'h0000_0000;
    endcase
    return {sel, arg};
  endfunction

endpackage

// File: rtl/sd_timeout_cnt.sv
// Clear/enable saturating counter with a terminal flag.
// The sequencer uses it for TX-start, response and inter-command gap timing.
module sd_timeout_cnt
  import sd_init_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_limit,
  output logic         o_term
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_cnt;

  // Count register: clear wins over enable, and the count holds at all-ones.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt <= {W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {W{1'b0}};
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + ONE;
    end
  end

  assign o_term = (r_cnt == i_limit);

endmodule

// File: rtl/sd_init_seq.sv
// SD card power-up sequencer: CMD0, CMD8, CMD55/ACMD41 polling, and optionally CMD2/CMD3.
// Define SD_INIT_RCA_EN to add CMD2/CMD3 and RCA capture; otherwise rca is tied to 0.
module sd_init_seq
  import sd_init_pkg::*;
#(
  parameter int          RESP_TIMEOUT   = 64,
  parameter int          TX_TIMEOUT     = 16,
  parameter int          GAP_CYCLES     = 8,
  parameter int          ACMD41_RETRIES = 255,
  parameter logic [31:0] ACMD41_ARG     = 32'h40FF_8000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  output logic        o_send_en,
  output logic [37:0] o_cmd_content,
  input  logic        i_sending,
  input  logic        i_resp_valid,
  input  logic [31:0] i_resp_arg,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [2:0]  o_err_code,
  output logic        o_ccs,
  output logic [15:0] o_rca
);

  // Terminal values are one below the budget because the counter starts at 0 on state entry.
  localparam logic [7:0] TX_LIM    = 8'(TX_TIMEOUT - 1);
  localparam logic [7:0] RESP_LIM  = 8'(RESP_TIMEOUT - 1);
  localparam logic [7:0] GAP_LIM   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] RETRY_LIM = 8'(ACMD41_RETRIES - 1);

  state_t      r_state, w_next;
  logic [5:0]  r_cmd_sel, w_cmd_sel;
  logic [7:0]  r_retry, w_retry;
  logic [31:0] r_resp, w_resp;
  logic [2:0]  r_err_code, w_err_code;
  logic        r_ccs, w_ccs;
  logic [15:0] r_rca, w_rca;
  logic        r_send_en, r_busy, r_done, r_error;
  logic [37:0] r_cmd_content;
  logic        w_cnt_en, w_cnt_clr, w_term;
  logic [7:0]  w_limit;
  logic        w_unused;

  assign w_unused  = ^r_resp;
  assign w_cnt_clr = (w_next != r_state);

  sd_timeout_cnt #(.W(8)) u_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_limit (w_limit),
    .o_term  (w_term)
  );

  // Next-state, command selection, response evaluation and counter control.
  always_comb begin
    w_next     = r_state;
    w_cmd_sel  = r_cmd_sel;
    w_retry    = r_retry;
    w_resp     = r_resp;
    w_err_code = r_err_code;
    w_ccs      = r_ccs;
`ifdef SD_INIT_RCA_EN
    w_rca      = r_rca;
`else
    w_rca      = 16'h0000;
`endif
    w_cnt_en   = 1'b0;
    w_limit    = GAP_LIM;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (i_start) begin
          w_next     = ST_ISSUE;
          w_cmd_sel  = CMD0;
          w_retry    = 8'd0;
          w_err_code = ERR_NONE;
          w_ccs      = 1'b0;
          w_rca      = 16'h0000;
        end else begin
          w_next = r_state;
        end
      end
      ST_ISSUE: w_next = ST_WAIT_TX_START;
      ST_WAIT_TX_START: begin
        w_cnt_en = 1'b1;
        w_limit  = TX_LIM;
        if (i_sending) begin
          w_next = ST_WAIT_TX_END;
        end else if (w_term) begin
          w_next     = ST_ERROR;
          w_err_code = ERR_TX_TO;
        end else begin
          w_next = ST_WAIT_TX_START;
        end
      end
      ST_WAIT_TX_END: begin
        if (!i_sending) begin
          if (r_cmd_sel == CMD0) begin
            w_next    = ST_GAP;
            w_cmd_sel = CMD8;
          end else begin
            w_next = ST_WAIT_RESP;
          end
        end else begin
          w_next = ST_WAIT_TX_END;
        end
      end
      ST_WAIT_RESP: begin
        w_cnt_en = 1'b1;
        w_limit  = RESP_LIM;
        if (i_resp_valid) begin
          w_resp = i_resp_arg;
          w_next = ST_EVAL;
        end else if (w_term) begin
          w_next     = ST_ERROR;
          w_err_code = ERR_RESP_TO;
        end else begin
          w_next = ST_WAIT_RESP;
        end
      end
      ST_EVAL: begin
        w_next = ST_GAP;
        case (r_cmd_sel)
          CMD8: begin
            if (r_resp[11:0] == CMD8_CHECK) begin
              w_cmd_sel = CMD55;
            end else begin
              w_next     = ST_ERROR;
              w_err_code = ERR_CMD8;
            end
          end
          CMD55: w_cmd_sel = ACMD41;
          ACMD41: begin
            if (r_resp[31]) begin
              w_ccs = r_resp[30];
`ifdef SD_INIT_RCA_EN
              w_cmd_sel = CMD2;
`else
              w_cmd_sel = SEL_END;
`endif
            end else begin
              w_retry = (r_retry != 8'hFF) ? (r_retry + 8'd1) : r_retry;
              if (r_retry >= RETRY_LIM) begin
                w_next     = ST_ERROR;
                w_err_code = ERR_RETRY;
              end else begin
                w_cmd_sel = CMD55;
              end
            end
          end
`ifdef SD_INIT_RCA_EN
          CMD2: w_cmd_sel = CMD3;
          CMD3: begin
            w_rca     = r_resp[31:16];
            w_cmd_sel = SEL_END;
          end
`endif
          default: w_cmd_sel = SEL_END;
        endcase
      end
      ST_GAP: begin
        w_cnt_en = 1'b1;
        w_limit  = GAP_LIM;
        if (w_term) begin
          w_next = (r_cmd_sel == SEL_END) ? ST_DONE : ST_ISSUE;
        end else begin
          w_next = ST_GAP;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // State and datapath registers; outputs are registered from the next state so they align with it.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state       <= ST_IDLE;
      r_cmd_sel     <= CMD0;
      r_retry       <= 8'd0;
      r_resp        <= 32'h0000_0000;
      r_err_code    <= ERR_NONE;
      r_ccs         <= 1'b0;
      r_rca         <= 16'h0000;
      r_send_en     <= 1'b0;
      r_cmd_content <= 38'h0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_cmd_sel  <= w_cmd_sel;
      r_retry    <= w_retry;
      r_resp     <= w_resp;
      r_err_code <= w_err_code;
      r_ccs      <= w_ccs;
      r_rca      <= w_rca;
      r_send_en  <= (w_next == ST_ISSUE);
      if (w_next == ST_ISSUE) begin
        r_cmd_content <= build_cmd(w_cmd_sel, w_rca, ACMD41_ARG);
      end
      r_busy  <= !((w_next == ST_IDLE) || (w_next == ST_DONE) || (w_next == ST_ERROR));
      r_done  <= (w_next == ST_DONE);
      r_error <= (w_next == ST_ERROR);
    end
  end

  assign o_send_en     = r_send_en;
  assign o_cmd_content = r_cmd_content;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;
  assign o_err_code    = r_err_code;
  assign o_ccs         = r_ccs;
  assign o_rca         = r_rca;

endmodule

// File: tb/tb_sd_init_seq.sv
// Self-checking bench for sd_init_seq: a card/sender model plus a rule-level reference
// for the expected command list and final status, with randomized card behaviour.
module tb_sd_init_seq;

  localparam int          RESP_TIMEOUT = 64;
  localparam int          TX_TIMEOUT   = 16;
  localparam int          GAP_CYCLES   = 8;
  localparam int          RETRIES      = 3;
  localparam logic [31:0] A41_ARG      = 32'h40FF_8000;

  logic        clk = 1'b0;
  logic        rst_n, start, send_en, sending, resp_valid;
  logic [37:0] cmd_content;
  logic [31:0] resp_arg;
  logic        busy, done, error, ccs;
  logic [2:0]  err_code;
  logic [15:0] rca;

  int n_vec = 0;
  int n_err = 0;

  logic [37:0] cmd_log[$];
  logic [37:0] exp_log[$];

  logic [31:0] cmd8_val;
  int          busy_n;
  int          a41_seen;
  logic        ccs_v;
  logic [15:0] rca_v;
  bit          suppress, tx_never;

  always #5 clk = ~clk;

  sd_init_seq #(
    .RESP_TIMEOUT   (RESP_TIMEOUT),
    .TX_TIMEOUT     (TX_TIMEOUT),
    .GAP_CYCLES     (GAP_CYCLES),
    .ACMD41_RETRIES (RETRIES),
    .ACMD41_ARG     (A41_ARG)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst_n),
    .i_start       (start),
    .o_send_en     (send_en),
    .o_cmd_content (cmd_content),
    .i_sending     (sending),
    .i_resp_valid  (resp_valid),
    .i_resp_arg    (resp_arg),
    .o_busy        (busy),
    .o_done        (done),
    .o_error       (error),
    .o_err_code    (err_code),
    .o_ccs         (ccs),
    .o_rca         (rca)
  );

  // Sender + card model: logs each command, raises sending 2 cycles after send_en for 48 cycles, then replies.
  initial begin
    logic [37:0] c;
    logic [31:0] r;
    sending = 1'b0; resp_valid = 1'b0; resp_arg = 32'h0;
    forever begin
      @(negedge clk);
      if (send_en === 1'b1) begin
        c = cmd_content;
        cmd_log.push_back(c);
        if (!tx_never) begin
          repeat (2) @(negedge clk);
          sending = 1'b1;
          repeat (48) @(negedge clk);
          sending = 1'b0;
          if (c[37:32] != 6'd0 && !(suppress && c[37:32] == 6'd8)) begin
            case (c[37:32])
              6'd8:  r = cmd8_val;
              6'd41: begin
                r = (a41_seen < busy_n) ? 32'h00FF_8000 : {1'b1, ccs_v, 30'h00FF_8000};
                a41_seen++;
              end
              6'd3:  r = {rca_v, 16'h0500};
              default: r = $urandom();
            endcase
            repeat ($urandom_range(1, 6)) @(negedge clk);
            resp_valid = 1'b1; resp_arg = r;
            @(negedge clk);
            resp_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: expected command list and error code from the card's configured behaviour.
  task automatic build_expect(output logic [2:0] e_err);
    int pairs;
    exp_log.delete();
    exp_log.push_back({6'd0, 32'h0});
    if (tx_never) begin e_err = 3'd4; return; end
    exp_log.push_back({6'd8, 32'h0000_01AA});
    if (suppress) begin e_err = 3'd2; return; end
    if (cmd8_val[11:0] != 12'h1AA) begin e_err = 3'd1; return; end
    pairs = (busy_n < RETRIES) ? busy_n + 1 : RETRIES;
    for (int i = 0; i < pairs; i++) begin
      exp_log.push_back({6'd55, 32'h0});
      exp_log.push_back({6'd41, A41_ARG});
    end
    if (busy_n >= RETRIES) begin e_err = 3'd3; return; end
`ifdef SD_INIT_RCA_EN
    exp_log.push_back({6'd2, 32'h0});
    exp_log.push_back({6'd3, 32'h0});
`endif
    e_err = 3'd0;
  endtask

  task automatic kick();
    cmd_log.delete();
    a41_seen = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic finish_check();
    logic [2:0]  e_err;
    logic [15:0] e_rca;
    int guard = 0;
    build_expect(e_err);
    while (!(done === 1'b1 || error === 1'b1) && guard < 3000) begin
      @(negedge clk); guard++;
    end
    check("end_reached", guard < 3000, 1'b1);
    repeat (20) @(negedge clk);
`ifdef SD_INIT_RCA_EN
    e_rca = (e_err == 3'd0) ? rca_v : 16'h0;
`else
    e_rca = 16'h0;
`endif
    check("done", done, e_err == 3'd0);
    check("error", error, e_err != 3'd0);
    check("err_code", err_code, e_err);
    check("busy_end", busy, 1'b0);
    check("ccs", ccs, (e_err == 3'd0) ? ccs_v : 1'b0);
    check("rca", rca, e_rca);
    check("log_len", cmd_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < cmd_log.size(); i++)
      check($sformatf("cmd%0d", i), cmd_log[i], exp_log[i]);
  endtask

  // Returns on the edge that samples the n-th falling of sending.
  task automatic wait_falls(input int n);
    int   seen = 0;
    int   guard = 0;
    logic prev = 1'b0;
    while (seen < n && guard < 2000) begin
      @(posedge clk); guard++;
      if (prev && !sending) seen++;
      prev = sending;
    end
    check("fall_seen", seen, n);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0;
    cmd8_val = 32'h0000_01AA; busy_n = 1; ccs_v = 1'b1; rca_v = 16'hB368;
    suppress = 1'b0; tx_never = 1'b0; a41_seen = 0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {send_en, cmd_content, busy, done, error, err_code, ccs, rca}, 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 1'b0);

    // nominal: one busy ACMD41 reply, then ready with CCS
    kick(); finish_check();

    for (int r = 0; r < 4; r++) begin
      busy_n = $urandom_range(0, 2);
      ccs_v  = 1'($urandom_range(0, 1));
      rca_v  = 16'($urandom());
      kick(); finish_check();
    end

    // start while busy is ignored
    busy_n = 0; ccs_v = 1'b1; rca_v = 16'hB368;
    kick();
    begin
      int g = 0;
      while (cmd_log.size() < 2 && g < 500) begin @(posedge clk); g++; end
      check("cmd8_seen", cmd_log.size() >= 2, 1'b1);
    end
    repeat (10) @(negedge clk);
    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    check("busy_start_cmd", cmd_content, {6'd8, 32'h0000_01AA});
    check("busy_start_busy", busy, 1'b1);
    finish_check();

    // CMD8 echo mismatch
    cmd8_val = 32'h0000_01AB;
    kick(); finish_check();
    cmd8_val = 32'h0000_01AA;

    // response timeout: error registers exactly RESP_TIMEOUT edges after sending is sampled low
    suppress = 1'b1;
    kick(); wait_falls(2);
    repeat (RESP_TIMEOUT - 1) @(posedge clk);
    #1 check("to_early", error, 1'b0);
    @(posedge clk);
    #1 check("to_edge", error, 1'b1);
    finish_check();

    // asynchronous reset while waiting for a response
    kick(); wait_falls(2);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check("rst_async", {send_en, cmd_content, busy, done, error, err_code, ccs, rca}, 64'h0);
    repeat (30) @(negedge clk);
    check("rst_no_send", cmd_log.size(), 2);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_release", {busy, done, error}, 3'b000);
    suppress = 1'b0;

    // retries exhausted
    busy_n = 99;
    kick(); finish_check();

    // sender never starts
    busy_n = 0; tx_never = 1'b1;
    kick(); finish_check();
    tx_never = 1'b0;

    // restart from ERROR
    ccs_v = 1'b0;
    kick(); finish_check();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
